// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with write bypass and busy scoreboard
// Decode reads operands combinationally, issue marks destinations busy, writeback writes and clears.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wen,
  input  logic [AW-1:0]        i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic                 i_set_busy,
  input  logic [AW-1:0]        i_set_addr,
  input  logic [NRD*AW-1:0]    i_raddr,
  output logic [NRD*WIDTH-1:0] o_rdata,
  output logic [NRD-1:0]       o_rbusy,
  output logic                 o_any_busy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic w_wr_ok;
  logic w_set_ok;

  // A write to r0 with ZERO_REG set is treated as if it never happened,
  // so it neither stores, clears busy, nor forwards.
  assign w_wr_ok  = !i_rst && i_wen &&
                    !((ZERO_REG != 0) && (i_waddr == '0));
  assign w_set_ok = !i_rst && i_set_busy &&
                    !((ZERO_REG != 0) && (i_set_addr == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[i_waddr] <= i_wdata;
      end
      // Set beats clear: a newer producer was issued in the same cycle.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_set_ok && (i_set_addr == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_ok && (i_waddr == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_rd;
    logic             w_rb;

    assign w_ra = i_raddr[k*AW +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
      w_rb = r_busy[w_ra];
      if ((BYPASS != 0) && w_wr_ok && (i_waddr == w_ra)) begin
        w_rd = i_wdata;
        w_rb = 1'b0;
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
    end

    assign o_rdata[k*WIDTH +: WIDTH] = w_rd;
    assign o_rbusy[k]                = w_rb;
  end

  assign o_any_busy = |r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized bench for regfile_sb against an array reference model
// Two instances cover both corners: (bypass, zero reg) and (no bypass, no zero reg).
module tb_regfile_sb;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int N  = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic          set_busy = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] set_addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [N*AW-1:0] raddr = '0;

  logic [N*W-1:0] rdata_a, rdata_b;
  logic [N-1:0]   rbusy_a, rbusy_b;
  logic           any_a, any_b;

  regfile_sb #(.WIDTH(W), .DEPTH(D), .NRD(N), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_set_busy(set_busy), .i_set_addr(set_addr), .i_raddr(raddr),
    .o_rdata(rdata_a), .o_rbusy(rbusy_a), .o_any_busy(any_a)
  );

  regfile_sb #(.WIDTH(W), .DEPTH(D), .NRD(N), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_set_busy(set_busy), .i_set_addr(set_addr), .i_raddr(raddr),
    .o_rdata(rdata_b), .o_rbusy(rbusy_b), .o_any_busy(any_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per configuration: index 0 = dut_a, 1 = dut_b.
  logic [W-1:0] m_reg  [2][D];
  bit           m_busy [2][D];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit we, input logic [AW-1:0] wa,
                      input logic [W-1:0] wd, input bit sb, input logic [AW-1:0] sa,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input bit chk);
    bit byp, zr, wr_eff, set_eff, any_exp;
    logic [AW-1:0] a;
    logic [W-1:0]  ed, gd;
    bit            eb, gb, ga;
    @(negedge clk);
    rst = r; wen = we; waddr = wa; wdata = wd;
    set_busy = sb; set_addr = sa;
    raddr = {ra1, ra0};
    #1;
    if (chk) begin
      for (int c = 0; c < 2; c++) begin
        byp    = (c == 0);
        zr     = (c == 0);
        wr_eff = !r && we && !(zr && wa == 0);
        any_exp = 1'b0;
        for (int i = 0; i < D; i++) any_exp = any_exp | m_busy[c][i];
        for (int k = 0; k < N; k++) begin
          a = (k == 0) ? ra0 : ra1;
          if (zr && a == 0) begin
            ed = '0; eb = 1'b0;
          end else if (byp && wr_eff && wa == a) begin
            ed = wd; eb = 1'b0;
          end else begin
            ed = m_reg[c][a]; eb = m_busy[c][a];
          end
          gd = (c == 0) ? rdata_a[k*W +: W] : rdata_b[k*W +: W];
          gb = (c == 0) ? rbusy_a[k] : rbusy_b[k];
          check($sformatf("cfg%0d_rdata%0d_addr%0d", c, k, a), 32'(gd), 32'(ed));
          check($sformatf("cfg%0d_rbusy%0d_addr%0d", c, k, a), 32'(gb), 32'(eb));
        end
        ga = (c == 0) ? any_a : any_b;
        check($sformatf("cfg%0d_any_busy", c), 32'(ga), 32'(any_exp));
      end
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      zr = (c == 0);
      if (r) begin
        for (int i = 0; i < D; i++) begin
          m_reg[c][i]  = '0;
          m_busy[c][i] = 1'b0;
        end
      end else begin
        wr_eff  = we && !(zr && wa == 0);
        set_eff = sb && !(zr && sa == 0);
        if (wr_eff) begin
          m_reg[c][wa]  = wd;
          m_busy[c][wa] = 1'b0;
        end
        if (set_eff) m_busy[c][sa] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [AW-1:0] wa, sa, r0, r1;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < D; i++) begin
        m_reg[c][i] = '0; m_busy[c][i] = 1'b0;
      end

    // Reset, then sweep every address on both ports.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < D; a++) step(0, 0, 0, 0, 0, 0, AW'(a), AW'(D-1-a), 1);

    // Same-cycle write/read of r5.
    step(0, 1, 5, 16'hBEEF, 0, 0, 5, 5, 1);
    step(0, 0, 0, 0, 0, 0, 5, 4, 1);

    // Writes and busy to r0.
    step(0, 1, 0, 16'h1234, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Busy r3, then writeback clears it.
    step(0, 0, 0, 0, 1, 3, 3, 3, 1);
    step(0, 0, 0, 0, 0, 0, 3, 3, 1);
    step(0, 1, 3, 16'h7777, 0, 0, 3, 3, 1);
    step(0, 0, 0, 0, 0, 0, 3, 3, 1);

    // Set and write the same register: set wins.
    step(0, 1, 7, 16'h00AA, 1, 7, 7, 7, 1);
    step(0, 0, 0, 0, 0, 0, 7, 7, 1);

    // Reset drops a concurrent write.
    step(0, 1, 2, 16'h0055, 1, 2, 2, 2, 1);
    step(0, 0, 0, 0, 0, 0, 2, 2, 1);
    step(1, 1, 2, 16'h0099, 0, 0, 2, 2, 1);
    step(0, 0, 0, 0, 0, 0, 2, 2, 1);

    // Randomized traffic biased toward collisions and r0.
    for (int n = 0; n < 600; n++) begin
      wa = AW'($urandom_range(0, D-1));
      if ($urandom_range(0, 7) == 0) wa = '0;
      sa = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, D-1));
      r0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, D-1));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : AW'($urandom_range(0, D-1));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), wa,
           W'($urandom), ($urandom_range(0, 9) < 4), sa, r0, r1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
